// File: rtl/id_exe_pipe.sv
// Decode-side forwarding and load-use hazard unit with the ID/EXE register.
// A bubble is loaded on a load-use stall or a flush of the ID instruction.
module id_exe_pipe #(
    parameter int WIDTH = 32,
    parameter int RW    = 5
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [RW-1:0]    rs,
    input  logic [RW-1:0]    rt,
    input  logic [RW-1:0]    rn,
    input  logic             users,
    input  logic             usert,
    input  logic [WIDTH-1:0] qa,
    input  logic [WIDTH-1:0] qb,
    input  logic [WIDTH-1:0] imm,
    input  logic [2:0]       aluc,
    input  logic             aluimm,
    input  logic             shift,
    input  logic             wreg,
    input  logic             m2reg,
    input  logic             wmem,
    input  logic             flush,
    input  logic [WIDTH-1:0] ealu,
    input  logic [RW-1:0]    mrn,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic [WIDTH-1:0] malu,
    input  logic [WIDTH-1:0] mmo,
    output logic [WIDTH-1:0] ea,
    output logic [WIDTH-1:0] eb,
    output logic [WIDTH-1:0] eimm,
    output logic [2:0]       ealuc,
    output logic             ealuimm,
    output logic             eshift,
    output logic             ewreg,
    output logic             em2reg,
    output logic             ewmem,
    output logic [RW-1:0]    ern,
    output logic             stall
);

    logic             e_fwd;
    logic             m_fwd;
    logic             e_lod;
    logic [WIDTH-1:0] mval;
    logic [WIDTH-1:0] fa;
    logic [WIDTH-1:0] fb;
    logic             bubble;

    // EXE can only forward ALU results; a load there is still in flight
    assign e_fwd = ewreg & ~em2reg & (ern != '0);
    assign e_lod = ewreg & em2reg & (ern != '0);
    assign m_fwd = mwreg & (mrn != '0);
    assign mval  = mm2reg ? mmo : malu;

    always_comb begin
        fa = qa;
        if (e_fwd && ern == rs)
            fa = ealu;
        else if (m_fwd && mrn == rs)
            fa = mval;
    end

    always_comb begin
        fb = qb;
        if (e_fwd && ern == rt)
            fb = ealu;
        else if (m_fwd && mrn == rt)
            fb = mval;
    end

    assign stall = e_lod & ((users & (ern == rs)) |
                            (usert & (ern == rt)));
    assign bubble = stall | flush;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ea      <= '0;
            eb      <= '0;
            eimm    <= '0;
            ealuc   <= '0;
            ealuimm <= 1'b0;
            eshift  <= 1'b0;
            ewreg   <= 1'b0;
            em2reg  <= 1'b0;
            ewmem   <= 1'b0;
            ern     <= '0;
        end else if (bubble) begin
            ea      <= '0;
            eb      <= '0;
            eimm    <= '0;
            ealuc   <= '0;
            ealuimm <= 1'b0;
            eshift  <= 1'b0;
            ewreg   <= 1'b0;
            em2reg  <= 1'b0;
            ewmem   <= 1'b0;
            ern     <= '0;
        end else begin
            ea      <= fa;
            eb      <= fb;
            eimm    <= imm;
            ealuc   <= aluc;
            ealuimm <= aluimm;
            eshift  <= shift;
            ewreg   <= wreg;
            em2reg  <= m2reg;
            ewmem   <= wmem;
            ern     <= rn;
        end
    end

endmodule

// File: tb/tb_id_exe_pipe.sv
// Scoreboard bench for id_exe_pipe: directed hazard cases plus random traffic
// checked against a behavioural model of the EXE-stage contents.
module tb_id_exe_pipe;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [2:0]  aluc;
        logic        aluimm;
        logic        shift;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [4:0]  rn;
    } es_t;

    logic        clk = 1'b0;
    logic        clrn;
    logic [4:0]  rs, rt, rn, mrn;
    logic        users, usert;
    logic [31:0] qa, qb, imm, ealu, malu, mmo;
    logic [2:0]  aluc;
    logic        aluimm, shift, wreg, m2reg, wmem, flush;
    logic        mwreg, mm2reg;
    logic [31:0] ea, eb, eimm;
    logic [2:0]  ealuc;
    logic        ealuimm, eshift, ewreg, em2reg, ewmem;
    logic [4:0]  ern;
    logic        stall;

    int checks = 0;
    int failures = 0;
    es_t me;
    es_t sb[$];
    logic st;

    id_exe_pipe #(.WIDTH(32), .RW(5)) dut (
        .clk(clk), .clrn(clrn),
        .rs(rs), .rt(rt), .rn(rn),
        .users(users), .usert(usert),
        .qa(qa), .qb(qb), .imm(imm),
        .aluc(aluc), .aluimm(aluimm), .shift(shift),
        .wreg(wreg), .m2reg(m2reg), .wmem(wmem),
        .flush(flush), .ealu(ealu),
        .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg),
        .malu(malu), .mmo(mmo),
        .ea(ea), .eb(eb), .eimm(eimm),
        .ealuc(ealuc), .ealuimm(ealuimm), .eshift(eshift),
        .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
        .ern(ern), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic es_t dut_e();
        es_t x;
        x = {ea, eb, eimm, ealuc, ealuimm, eshift,
             ewreg, em2reg, ewmem, ern};
        return x;
    endfunction

    // Youngest producer of register r wins; r0 is hard-wired zero
    function automatic logic [31:0] pick(input logic [4:0] r,
                                         input logic [31:0] rf);
        if (r == 5'd0) return rf;
        if (me.wreg && !me.m2reg && me.rn == r) return ealu;
        if (mwreg && mrn == r) return mm2reg ? mmo : malu;
        return rf;
    endfunction

    function automatic logic mstall();
        if (!(me.wreg && me.m2reg) || me.rn == 5'd0) return 1'b0;
        return (users && me.rn == rs) || (usert && me.rn == rt);
    endfunction

    always @(posedge clk) begin
        es_t x;
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("estage", dut_e(), x);
        end
    end

    task automatic step(output logic s);
        es_t nx;
        logic ms;
        #1;
        ms = mstall();
        s = stall;
        chk("stall", stall, ms);
        if (ms || flush) nx = '0;
        else nx = '{a: pick(rs, qa), b: pick(rt, qb), imm: imm,
                   aluc: aluc, aluimm: aluimm, shift: shift,
                   wreg: wreg, m2reg: m2reg, wmem: wmem, rn: rn};
        sb.push_back(nx);
        @(posedge clk);
        me = nx;
        #2;
    endtask

    task automatic idle();
        rs = 0; rt = 0; rn = 0; users = 0; usert = 0;
        qa = 0; qb = 0; imm = 0; aluc = 0;
        aluimm = 0; shift = 0; wreg = 0; m2reg = 0; wmem = 0;
        flush = 0; ealu = 0; mrn = 0; mwreg = 0; mm2reg = 0;
        malu = 0; mmo = 0;
    endtask

    task automatic rnd();
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rn = 5'($urandom_range(0, 7));
        mrn = 5'($urandom_range(0, 7));
        users = 1'($urandom); usert = 1'($urandom);
        qa = $urandom; qb = $urandom; imm = $urandom;
        ealu = $urandom; malu = $urandom; mmo = $urandom;
        aluc = 3'($urandom); aluimm = 1'($urandom);
        shift = 1'($urandom); wreg = 1'($urandom);
        m2reg = ($urandom_range(0, 2) == 0);
        wmem = 1'($urandom); flush = ($urandom_range(0, 7) == 0);
        mwreg = 1'($urandom); mm2reg = 1'($urandom);
    endtask

    task automatic ld(input logic [4:0] r);
        idle(); wreg = 1; m2reg = 1; rn = r;
        step(st);
    endtask

    initial begin
        me = '0;
        clrn = 1'b0;
        rnd();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_e", dut_e(), '0);
        chk("reset_stall", stall, 1'b0);
        @(negedge clk);
        clrn = 1'b1;

        idle(); rs = 1; rt = 2; rn = 3; qa = 5; qb = 7;
        users = 1; usert = 1; wreg = 1;
        step(st);
        chk("add_ea", ea, 32'd5);
        chk("add_eb", eb, 32'd7);
        chk("add_ewreg", ewreg, 1'b1);
        chk("add_ern", ern, 5'd3);

        idle(); rs = 3; users = 1; ealu = 32'h12;
        step(st);
        chk("efwd_stall", st, 1'b0);
        chk("efwd_ea", ea, 32'h12);

        idle(); wreg = 1; rn = 4;
        step(st);
        idle(); rt = 4; usert = 1; ealu = 32'hA; malu = 32'hB;
        mrn = 4; mwreg = 1;
        step(st);
        chk("prio_eb", eb, 32'hA);
        idle(); rt = 4; usert = 1; mrn = 4; mwreg = 1;
        mm2reg = 1; mmo = 32'hC; malu = 32'hB;
        step(st);
        chk("mfwd_eb", eb, 32'hC);

        ld(5);
        idle(); rs = 5; users = 1; wreg = 1; rn = 6;
        step(st);
        chk("lu_stall", st, 1'b1);
        chk("lu_bub_wreg", ewreg, 1'b0);
        chk("lu_bub_rn", ern, 5'd0);
        mrn = 5; mwreg = 1; mm2reg = 1; mmo = 32'h99;
        step(st);
        chk("lu_retry_stall", st, 1'b0);
        chk("lu_retry_ea", ea, 32'h99);

        ld(5);
        idle(); rs = 5; wreg = 1; rn = 6;
        step(st);
        chk("nouse_stall", st, 1'b0);
        chk("nouse_wreg", ewreg, 1'b1);

        idle(); wreg = 1; rn = 0;
        step(st);
        idle(); rs = 0; users = 1; ealu = 32'hFF;
        step(st);
        chk("r0_ea", ea, 32'h0);
        ld(0);
        idle(); rs = 0; users = 1;
        step(st);
        chk("r0_ld_stall", st, 1'b0);

        idle(); wmem = 1; rs = 1; rt = 2; flush = 1;
        step(st);
        chk("fl_wmem", ewmem, 1'b0);
        chk("fl_wreg", ewreg, 1'b0);
        ld(6);
        idle(); rs = 6; users = 1; flush = 1; wreg = 1;
        step(st);
        chk("flst_stall", st, 1'b1);
        chk("flst_bub", ewreg, 1'b0);

        ld(7);
        idle(); rs = 7; users = 1; wreg = 1; rn = 2; qa = 32'h55;
        #1;
        chk("rst_pre_stall", stall, 1'b1);
        clrn = 1'b0;
        #1;
        chk("rst_mid_e", dut_e(), '0);
        chk("rst_mid_stall", stall, 1'b0);
        me = '0;
        clrn = 1'b1;
        step(st);
        chk("rst_after_ea", ea, 32'h55);

        for (int i = 0; i < 400; i++) begin
            rnd();
            step(st);
        end

        #20;
        chk("sb_drained", 128'(sb.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_exe_pipe.md
Name: id_exe_pipe

Overview:
- Decode-side forwarding/hazard unit plus the ID/EXE pipeline register of the forwarding/stall pipelined CPU.
- Selects each ALU source operand from the register file, the EXE result or the MEM stage, and detects load-use hazards.
- On a hazard it inserts a bubble; otherwise it registers decoded control and data into the EXE stage on every clock.
- Its registered outputs drive the execute stage's ealuc, ealuimm, eshift, ea, eb and eimm inputs directly.

Parameters:
- WIDTH, 32, datapath width of operands and immediate.
- RW, 5, register-number width.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- clrn  in  1  asynchronous active-low reset.
- rs  in  RW  ID source register a number.
- rt  in  RW  ID source register b number.
- rn  in  RW  ID destination register number.
- users  in  1  ID instruction reads rs.
- usert  in  1  ID instruction reads rt.
- qa  in  WIDTH  register-file read data a.
- qb  in  WIDTH  register-file read data b.
- imm  in  WIDTH  ID extended immediate.
- aluc  in  3  ID ALU control.
- aluimm  in  1  ID immediate-select.
- shift  in  1  ID shift-select.
- wreg  in  1  ID register-write control.
- m2reg  in  1  ID load control.
- wmem  in  1  ID memory-write control.
- flush  in  1  kill the ID instruction (taken branch/jump); it enters EXE as a bubble.
- ealu  in  WIDTH  EXE-stage ALU result, fed back for forwarding.
- mrn  in  RW  MEM-stage destination register number.
- mwreg  in  1  MEM-stage register-write control.
- mm2reg  in  1  MEM-stage load control.
- malu  in  WIDTH  MEM-stage ALU result.
- mmo  in  WIDTH  MEM-stage memory read data.
- ea  out  WIDTH  registered operand a.
- eb  out  WIDTH  registered operand b (store data when ewmem).
- eimm  out  WIDTH  registered immediate.
- ealuc  out  3  registered ALU control.
- ealuimm  out  1  registered immediate-select.
- eshift  out  1  registered shift-select.
- ewreg  out  1  registered write-back control.
- em2reg  out  1  registered load control.
- ewmem  out  1  registered store control.
- ern  out  RW  registered destination register number.
- stall  out  1  combinational; 1 means the PC and IF/ID registers must hold.

Behaviour:
- Reset: clrn=0 asynchronously clears every registered output to 0, including ea/eb/eimm and ern. stall then evaluates to 0 because ewreg=0.
- Forward select for operand a, evaluated combinationally:
  - if ewreg & ~em2reg & ern!=0 & ern==rs -> ealu;
  - else if mwreg & mrn!=0 & mrn==rs -> mmo when mm2reg, else malu;
  - else qa.
- Operand b uses the same rule with rt/qb.
- EXE match beats MEM match. Register 0 is never forwarded.
- stall = ewreg & em2reg & ern!=0 & ((users & ern==rs) | (usert & ern==rt)).
- Rising edge with stall=0 and flush=0: load the forwarded a/b, imm and all ID controls.
- Rising edge with stall=1 or flush=1: load a bubble:
  - ewreg, em2reg and ewmem = 0; ern = 0;
  - ealuc, ealuimm and eshift = 0; ea, eb and eimm = 0.
- stall and flush together: bubble. stall still reports 1; upstream gives flush priority over the PC hold.
- A stalled instruction re-evaluates next cycle. The load is then in MEM, so the operand forwards from mmo. Latency is exactly one bubble per load-use.
- rs/rt matches are forwarded even when users/usert=0. This is harmless: the unused operand is ignored downstream. Only stall is qualified by users/usert.
- No internal state beyond the pipeline register; no FSM. A reset mid-stall clears the bubble state; the next edge loads ID normally.

Test Plan:
- Reset: clrn=0 with random inputs -> every output 0, stall=0. Release clrn; ID add r3=r1+r2 with qa=5, qb=7 -> next edge ea=5, eb=7, ewreg=1, ern=3.
- EXE forward: E holds ewreg=1, em2reg=0, ern=3; ealu=0x12; ID rs=3, qa=0 -> next edge ea=0x12, stall=0.
- Priority: EXE and MEM both target r4 (ealu=0xA, malu=0xB, mwreg=1); ID rt=4 -> eb=0xA. Repeat with mrn=4 only and mm2reg=1, mmo=0xC -> eb=0xC.
- Load-use: E holds em2reg=1, ewreg=1, ern=5; ID rs=5, users=1 -> stall=1. Next edge: bubble (ewreg=0, ern=0).
  - Following cycle: mrn=5, mm2reg=1, mmo=0x99 -> stall=0, next edge ea=0x99.
  - Same case with users=0, usert=0 -> stall=0, no bubble.
- Register zero: ern=0, ewreg=1, ealu=0xFF; ID rs=0, qa=0 -> ea=0. Load with ern=0 -> stall=0.
- Flush: flush=1 with a valid ID store (wmem=1) -> next edge ewmem=0, ewreg=0. Flush together with stall -> bubble, stall=1.
